// File: rtl/shift_count_reg_cell.sv
// WIDTH-bit storage/sequencing cell: hold, parallel load, shift, rotate and up/down count,
// with synchronous reset/set and chainable serial and terminal-count outputs.
module shift_count_reg_cell #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             r,
  input  logic             s,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  logic [WIDTH-1:0] q_next;

  // Mode datapath only; reset, set and enable priority are applied in the register.
  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin};
      MODE_SHR:  q_next = {sin, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_UP:   q_next = q + WIDTH'(1);
      MODE_DOWN: q_next = q - WIDTH'(1);
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r)
      q <= RESET_VAL;
    else if (s)
      q <= SET_VAL;
    else if (en)
      q <= q_next;
  end

  assign notq   = ~q;
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  // Flags the cycle whose next edge wraps the counter; drives the next stage's en when chained.
  assign tc = en & (((mode == MODE_UP) & (q == '1)) | ((mode == MODE_DOWN) & (q == '0)));

endmodule
